// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP frame writer.
//   HDR_BYTES/INFO_SIZE/BPP/PPM : fixed BMP header constants
//   state_t                     : frame FSM state encoding
//   hdr_byte()                  : returns header byte idx (0..53) of a 24-bpp file
package bmp_pkg;

   localparam int HDR_BYTES = 54;
   localparam int INFO_SIZE = 40;
   localparam int BPP       = 24;
   localparam int PPM       = 2835;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PIX,
      S_EMIT,
      S_PAD,
      S_FLUSH,
      S_DONE
   } state_t;

   // After the two-byte signature every header field is a 32-bit little-endian
   // word starting at offset 2+4n. planes (16b) and bpp (16b) are treated as
   // one combined word, which keeps the lookup a simple field index/byte lane.
   function automatic logic [7:0] hdr_byte(
      input logic [5:0]  idx,
      input logic [31:0] fsize,
      input logic [31:0] width,
      input logic [31:0] height,
      input logic [31:0] img
   );
      logic [5:0]  rel;
      logic [31:0] field;
      logic [7:0]  result;
      rel = idx - 6'd2;
      case (rel[5:2])
         4'd0:        field = fsize;
         4'd2:        field = 32'(HDR_BYTES);
         4'd3:        field = 32'(INFO_SIZE);
         4'd4:        field = width;
         4'd5:        field = height;
         4'd6:        field = {16'(BPP), 16'd1};
         4'd8:        field = img;
         4'd9, 4'd10: field = 32'(PPM);
         default:     field = '0;
      endcase
      result = 8'(field >> {rel[1:0], 3'b000});
      if (idx == 6'd0) result = 8'h42;
      if (idx == 6'd1) result = 8'h4D;
      return result;
   endfunction

endpackage

// File: rtl/bmp_frame_writer_packer.sv
// bmp_byte_packer: packs a byte stream into little-endian 32-bit SRAM writes.
//   clk, rst      : clock, synchronous active-high reset
//   byte_data     : file byte to place in the current lane
//   byte_valid    : byte_data is consumed this cycle
//   flush         : write any partial word, then restart at word address 0
//   addr/wdata    : registered SRAM word address / data
//   wren          : registered byte enables, zero whenever cs is low
//   cs            : one-cycle write strobe
import bmp_pkg::*;

module bmp_byte_packer #(
   parameter int AW = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    byte_data,
   input  logic          byte_valid,
   input  logic          flush,
   output logic [AW-1:0] addr,
   output logic [31:0]   wdata,
   output logic [3:0]    wren,
   output logic          cs
);

   logic [1:0]    lane;
   logic [23:0]   buf_q;
   logic [AW-1:0] word_cnt;
   logic [3:0]    part_mask;

   always_comb begin
      part_mask = 4'h0;
      case (lane)
         2'd1:    part_mask = 4'b0001;
         2'd2:    part_mask = 4'b0011;
         2'd3:    part_mask = 4'b0111;
         default: part_mask = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane     <= 2'd0;
         buf_q    <= '0;
         word_cnt <= '0;
         addr     <= '0;
         wdata    <= '0;
         wren     <= 4'h0;
         cs       <= 1'b0;
      end else begin
         cs   <= 1'b0;
         wren <= 4'h0;
         if (flush) begin
            // buf_q is cleared after every full word, so unwritten lanes are already 0
            if (lane != 2'd0) begin
               cs    <= 1'b1;
               wren  <= part_mask;
               wdata <= {8'h00, buf_q};
               addr  <= word_cnt;
            end
            lane     <= 2'd0;
            buf_q    <= '0;
            word_cnt <= '0;
         end else if (byte_valid) begin
            case (lane)
               2'd0: buf_q[7:0]   <= byte_data;
               2'd1: buf_q[15:8]  <= byte_data;
               2'd2: buf_q[23:16] <= byte_data;
               default: begin
                  cs       <= 1'b1;
                  wren     <= 4'hF;
                  wdata    <= {byte_data, buf_q};
                  addr     <= word_cnt;
                  word_cnt <= word_cnt + 1'b1;
                  buf_q    <= '0;
               end
            endcase
            lane <= lane + 2'd1;
         end
      end
   end

endmodule

// File: rtl/bmp_frame_writer.sv
// bmp_frame_writer: streams 24-bit pixels into a complete bottom-up 24-bpp BMP
// file image in word-addressed SRAM (header, B/G/R bytes, row padding).
//   CLK, RST            : clock, synchronous active-high reset
//   START               : begin a frame (ignored while BUSY)
//   WIDTH, HEIGHT       : image size, latched on an accepted START
//   PIX_VALID/PIX_DATA  : pixel stream {R,G,B}; PIX_READY accepts it
//   ADDR/WDATA/WREN/CS  : SRAM write port
//   BUSY, DONE          : frame in progress / one-cycle completion pulse
//
// state   | meaning
// S_IDLE  | waiting for START
// S_HDR   | emitting the 54 header bytes
// S_PIX   | waiting for a pixel; emits B on handshake
// S_EMIT  | emitting G then R of the captured pixel
// S_PAD   | emitting zero padding at end of row
// S_FLUSH | writing the trailing partial word
// S_DONE  | completion pulse
import bmp_pkg::*;

module bmp_frame_writer #(
   parameter int AW = 19,
   parameter int DW = 12
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [DW-1:0] WIDTH,
   input  logic [DW-1:0] HEIGHT,
   input  logic          PIX_VALID,
   input  logic [23:0]   PIX_DATA,
   output logic          PIX_READY,
   output logic [AW-1:0] ADDR,
   output logic [31:0]   WDATA,
   output logic [3:0]    WREN,
   output logic          CS,
   output logic          BUSY,
   output logic          DONE
);

   localparam logic [DW-1:0] ONE = 1;

   state_t        state_q, state_d;
   logic [5:0]    hdr_cnt_q;
   logic [DW-1:0] col_q, row_q;
   logic          emit_q;
   logic [1:0]    pad_cnt_q;
   logic [DW-1:0] width_q, height_q;
   logic [1:0]    pad_q;
   logic [31:0]   fsize_q, img_q;
   logic [7:0]    pix_g_q, pix_r_q;

   logic [31:0]   w3, stride, img_calc, fsize_calc;
   logic [1:0]    pad_calc;

   logic [7:0]    byte_data;
   logic          byte_valid, flush;
   logic          col_last, row_last, row_end;

   // stride is 3*W rounded up to a multiple of 4, so pad = (-3W) mod 4
   always_comb begin
      w3         = 32'(WIDTH) * 32'd3;
      stride     = (w3 + 32'd3) & ~32'd3;
      img_calc   = stride * 32'(HEIGHT);
      fsize_calc = img_calc + 32'(HDR_BYTES);
      pad_calc   = 2'd0 - w3[1:0];
   end

   always_comb begin
      state_d    = state_q;
      byte_data  = 8'h00;
      byte_valid = 1'b0;
      flush      = 1'b0;
      row_end    = 1'b0;
      col_last   = (col_q == width_q - ONE);
      row_last   = (row_q == height_q - ONE);
      case (state_q)
         S_IDLE: begin
            if (START) state_d = S_HDR;
         end
         S_HDR: begin
            byte_data  = hdr_byte(hdr_cnt_q, fsize_q, 32'(width_q), 32'(height_q), img_q);
            byte_valid = 1'b1;
            if (hdr_cnt_q == 6'(HDR_BYTES - 1))
               state_d = (width_q == '0 || height_q == '0) ? S_FLUSH : S_PIX;
         end
         S_PIX: begin
            byte_data  = PIX_DATA[7:0];
            byte_valid = PIX_VALID;
            if (PIX_VALID) state_d = S_EMIT;
         end
         S_EMIT: begin
            byte_data  = emit_q ? pix_r_q : pix_g_q;
            byte_valid = 1'b1;
            if (emit_q) begin
               if (!col_last) begin
                  state_d = S_PIX;
               end else if (pad_q != 2'd0) begin
                  state_d = S_PAD;
               end else begin
                  row_end = 1'b1;
                  state_d = row_last ? S_FLUSH : S_PIX;
               end
            end
         end
         S_PAD: begin
            byte_valid = 1'b1;
            if (pad_cnt_q == pad_q - 2'd1) begin
               row_end = 1'b1;
               state_d = row_last ? S_FLUSH : S_PIX;
            end
         end
         S_FLUSH: begin
            flush   = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         hdr_cnt_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
         emit_q    <= 1'b0;
         pad_cnt_q <= '0;
         width_q   <= '0;
         height_q  <= '0;
         pad_q     <= '0;
         fsize_q   <= '0;
         img_q     <= '0;
         pix_g_q   <= '0;
         pix_r_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  width_q   <= WIDTH;
                  height_q  <= HEIGHT;
                  pad_q     <= pad_calc;
                  img_q     <= img_calc;
                  fsize_q   <= fsize_calc;
                  hdr_cnt_q <= '0;
               end
            end
            S_HDR: begin
               hdr_cnt_q <= hdr_cnt_q + 6'd1;
               col_q     <= '0;
               row_q     <= '0;
            end
            S_PIX: begin
               if (PIX_VALID) begin
                  pix_g_q <= PIX_DATA[15:8];
                  pix_r_q <= PIX_DATA[23:16];
                  emit_q  <= 1'b0;
               end
            end
            S_EMIT: begin
               emit_q    <= ~emit_q;
               pad_cnt_q <= '0;
               if (emit_q) col_q <= col_last ? '0 : col_q + ONE;
            end
            S_PAD: begin
               pad_cnt_q <= pad_cnt_q + 2'd1;
            end
            default: ;
         endcase
         if (row_end) row_q <= row_q + ONE;
      end
   end

   bmp_byte_packer #(.AW(AW)) u_packer (
      .clk        (CLK),
      .rst        (RST),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .flush      (flush),
      .addr       (ADDR),
      .wdata      (WDATA),
      .wren       (WREN),
      .cs         (CS)
   );

   assign PIX_READY = (state_q == S_PIX);
   assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign DONE      = (state_q == S_DONE);

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Directed self-checking bench for bmp_frame_writer.
module tb_bmp_frame_writer;

   logic        CLK = 1'b0;
   logic        RST, START, PIX_VALID;
   logic [11:0] WIDTH, HEIGHT;
   logic [23:0] PIX_DATA;
   logic        PIX_READY;
   logic [18:0] ADDR;
   logic [31:0] WDATA;
   logic [3:0]  WREN;
   logic        CS, BUSY, DONE;

   int tests = 0;
   int fails = 0;

   logic [18:0] wr_addr [0:511];
   logic [31:0] wr_data [0:511];
   logic [3:0]  wr_en   [0:511];
   int          wr_cnt = 0;
   int          rdy_cnt = 0;
   int          stray_wren = 0;

   logic [23:0] pix [0:63];

   // hand-computed 2x2 frame: fsize 70, stride 8, pad 2
   logic [31:0] exp22 [0:17] = '{
      32'h00464D42, 32'h00000000, 32'h00360000, 32'h00280000,
      32'h00020000, 32'h00020000, 32'h00010000, 32'h00000018,
      32'h00100000, 32'h0B130000, 32'h0B130000, 32'h00000000,
      32'h00000000, 32'h22110000, 32'h66554433, 32'h88770000,
      32'hCCBBAA99, 32'h00000000};

   always #5 CLK = ~CLK;

   bmp_frame_writer dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .PIX_VALID (PIX_VALID),
      .PIX_DATA  (PIX_DATA),
      .PIX_READY (PIX_READY),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .WREN      (WREN),
      .CS        (CS),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   always @(negedge CLK) begin
      if (CS) begin
         if (wr_cnt < 512) begin
            wr_addr[wr_cnt] = ADDR;
            wr_data[wr_cnt] = WDATA;
            wr_en[wr_cnt]   = WREN;
         end
         wr_cnt++;
      end else if (WREN != 4'h0) begin
         stray_wren++;
      end
      if (PIX_READY) rdy_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input int base, input int i,
                             input logic [31:0] d, input logic [3:0] e);
      check($sformatf("%s_word%0d", tag, i),
            {9'd0, wr_addr[base+i], wr_data[base+i], wr_en[base+i]},
            {9'd0, 19'(i), d, e});
   endtask

   task automatic run_frame(input int w, input int h, input bit stall, input bit poke);
      int  idx;
      bit  seen_done;
      idx = 0;
      seen_done = 1'b0;
      @(negedge CLK);
      WIDTH = 12'(w); HEIGHT = 12'(h); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      WIDTH = 12'd9; HEIGHT = 12'd9;
      for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
         PIX_VALID = (idx < w * h) && (!stall || (cyc % 2) == 0);
         PIX_DATA  = pix[idx % 64];
         START     = poke && (cyc == 20 || cyc == 60);
         #1;
         if (cyc == 0) check("busy_after_start", BUSY, 1'b1);
         if (PIX_VALID && PIX_READY) idx++;
         if (DONE) seen_done = 1'b1;
         @(negedge CLK);
      end
      PIX_VALID = 1'b0;
      START = 1'b0;
      check("done_seen", seen_done, 1'b1);
      check("pixels_consumed", idx, w * h);
   endtask

   initial begin
      int base, rbase, idx;
      RST = 1'b1; START = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0;
      WIDTH = '0; HEIGHT = '0;
      repeat (3) @(negedge CLK);
      #1;
      check("reset_outputs", {PIX_READY, ADDR, WDATA, WREN, CS, BUSY, DONE}, '0);
      RST = 1'b0;

      // 1x1 frame
      pix[0] = 24'h302010;
      base = wr_cnt;
      run_frame(1, 1, 1'b0, 1'b0);
      check("w1h1_writes", wr_cnt - base, 15);
      check_word("w1h1", base, 0, 32'h003A4D42, 4'hF);
      check_word("w1h1", base, 9, 32'h0B130000, 4'hF);
      check_word("w1h1", base, 13, 32'h20100000, 4'hF);
      check_word("w1h1", base, 14, 32'h00000030, 4'b0011);

      // 2x2 frame with row padding
      pix[0] = 24'h332211; pix[1] = 24'h665544;
      pix[2] = 24'h998877; pix[3] = 24'hCCBBAA;
      base = wr_cnt;
      run_frame(2, 2, 1'b0, 1'b0);
      check("w2h2_writes", wr_cnt - base, 18);
      for (int i = 0; i < 18; i++)
         check_word("w2h2", base, i, exp22[i], (i == 17) ? 4'b0011 : 4'hF);

      // 4x1 frame, no padding, stalled pixel stream
      pix[0] = 24'hA09080; pix[1] = 24'hA19181;
      pix[2] = 24'hA29282; pix[3] = 24'hA39383;
      base = wr_cnt;
      run_frame(4, 1, 1'b1, 1'b0);
      check("w4h1_writes", wr_cnt - base, 17);
      check_word("w4h1", base, 0, 32'h00424D42, 4'hF);
      check_word("w4h1", base, 4, 32'h00040000, 4'hF);
      check_word("w4h1", base, 13, 32'h90800000, 4'hF);
      check_word("w4h1", base, 14, 32'hA19181A0, 4'hF);
      check_word("w4h1", base, 15, 32'h83A29282, 4'hF);
      check_word("w4h1", base, 16, 32'h0000A393, 4'b0011);

      // zero width: header only
      base = wr_cnt;
      rbase = rdy_cnt;
      run_frame(0, 5, 1'b0, 1'b0);
      check("w0_writes", wr_cnt - base, 14);
      check("w0_ready_never", rdy_cnt - rbase, 0);
      check_word("w0", base, 0, 32'h00364D42, 4'hF);
      check_word("w0", base, 5, 32'h00050000, 4'hF);
      check_word("w0", base, 8, 32'h00000000, 4'hF);
      check_word("w0", base, 13, 32'h00000000, 4'b0011);

      // reset during EMIT of an 8x8 frame
      for (int i = 0; i < 64; i++) pix[i] = 24'h010203 + 24'(i);
      @(negedge CLK);
      WIDTH = 12'd8; HEIGHT = 12'd8; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 500 && idx < 3; cyc++) begin
         PIX_VALID = 1'b1;
         PIX_DATA  = pix[idx];
         #1;
         if (PIX_READY) idx++;
         @(negedge CLK);
      end
      check("rst_pixels_before", idx, 3);
      RST = 1'b1;
      @(negedge CLK);
      #1;
      check("rst_mid_outputs", {PIX_READY, ADDR, WDATA, WREN, CS, BUSY, DONE}, '0);
      RST = 1'b0;
      base = wr_cnt;
      repeat (20) @(negedge CLK);
      check("rst_no_more_writes", wr_cnt - base, 0);
      check("rst_idle", {BUSY, DONE}, 2'b00);
      PIX_VALID = 1'b0;
      pix[0] = 24'h302010;
      base = wr_cnt;
      run_frame(1, 1, 1'b0, 1'b0);
      check("after_rst_writes", wr_cnt - base, 15);
      check_word("after_rst", base, 0, 32'h003A4D42, 4'hF);
      check_word("after_rst", base, 14, 32'h00000030, 4'b0011);

      // START pulses mid-frame are ignored
      pix[0] = 24'h332211; pix[1] = 24'h665544;
      pix[2] = 24'h998877; pix[3] = 24'hCCBBAA;
      base = wr_cnt;
      run_frame(2, 2, 1'b0, 1'b1);
      check("poke_writes", wr_cnt - base, 18);
      for (int i = 0; i < 18; i++)
         check_word("poke", base, i, exp22[i], (i == 17) ? 4'b0011 : 4'hF);

      check("no_stray_wren", stray_wren, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bmp_frame_writer.md
Name: bmp_frame_writer

Overview:
Converts a processed 24-bit pixel stream into a complete 24-bpp BMP file image in word-addressed on-chip SRAM. It is the write side of the dehaze datapath: the recovered-image pixels go in, and the file image comes out over the SRAM port (ADDR/WDATA/WREN/CS). The block generates the 54-byte header, serialises pixels B,G,R, inserts row padding, and packs bytes into little-endian 32-bit words. Host readback and file dump read this SRAM directly.

Parameters:
AW, 19, SRAM word-address width (2^19 words, enough for a 2,000,000-byte file)
DW, 12, width of the WIDTH/HEIGHT inputs in pixels

Ports:
CLK  in  1  single clock
RST  in  1  synchronous reset, active-high
START  in  1  one-cycle pulse; begins a frame; ignored while BUSY=1
WIDTH  in  DW  image width in pixels; latched on accepted START
HEIGHT  in  DW  image height in rows; latched on accepted START; file is bottom-up, so stream order equals file order
PIX_VALID  in  1  pixel available
PIX_DATA  in  24  {R[23:16],G[15:8],B[7:0]}
PIX_READY  out  1  pixel accepted when PIX_VALID&PIX_READY
ADDR  out  AW  SRAM word address, starting at 0
WDATA  out  32  byte k of file word at bits [8k+7:8k]
WREN  out  4  byte enables; 0 whenever CS=0
CS  out  1  one-cycle write strobe per word
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse after the final write

Behaviour:
- The single clock is CLK. Reset is RST: synchronous and active-high. RST=1 drives all outputs to 0 and the FSM to IDLE. A reset mid-frame discards the partial word and issues no further writes.
- Derived values, latched at START:
  - stride = (3*WIDTH+3) & ~3
  - pad = stride - 3*WIDTH (range 0..3)
  - img = stride*HEIGHT
  - fsize = 54 + img
  - All are 32-bit unsigned.
- Header bytes 0..53, little-endian multi-byte fields:
  - 'B'(0x42), 'M'(0x4D), fsize, 0(4 bytes), 54
  - 40, WIDTH, HEIGHT (positive), planes=1 (2 bytes), bpp=24 (2 bytes), compression=0
  - img, 2835, 2835, 0, 0
- The datapath emits exactly one file byte per cycle in byte-producing states. A 2-bit lane counter places each byte. When lane 3 is filled, the next cycle registers CS=1, WREN=4'hF, ADDR=word counter, WDATA=assembled word; the word counter then increments.
- FSM:
  - IDLE: PIX_READY=0. An accepted START sets BUSY=1 next cycle and goes to HDR.
  - HDR: 54 cycles, one header byte each. Then PIX, or FLUSH if WIDTH=0 or HEIGHT=0.
  - PIX: PIX_READY=1. On handshake, capture the pixel, emit B this cycle, go to EMIT. With no handshake, stall; no byte is emitted and no write occurs.
  - EMIT: 2 cycles, G then R. After the last pixel of a row, go to PAD if pad>0, else end of row.
  - PAD: pad cycles of byte 0x00, then end of row.
  - End of row: if the row count equals HEIGHT, go to FLUSH; else go to PIX.
  - FLUSH: if lane≠0, write the partial word with WREN set for lanes 0..lane-1 and unwritten bytes as 0. Then DONE.
  - DONE: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Because fsize ≡ 2 mod 4 always, the last write always has WREN=4'b0011. Total writes = ceil(fsize/4).
- PIX_READY is high only in PIX, so peak throughput is one pixel per 3 cycles.
- START while BUSY is ignored. If a START pulse and RST coincide, RST wins.
- The word counter wraps modulo 2^AW. Keeping the frame within SRAM capacity is the caller's responsibility.

Decomposition:
- Package bmp_pkg holds:
  - constants HDR_BYTES=54, INFO_SIZE=40, BPP=24, PPM=2835
  - the FSM state enum
  - function hdr_byte(idx, fsize, width, height, img) returning the header byte
- One natural sub-module, bmp_byte_packer: lane counter, word assembly, flush/byte-enable generation, and the ADDR/WDATA/WREN/CS registers. Inputs: byte, byte_valid, flush.

Test Plan:
- W=1,H=1, pixel {R=0x30,G=0x20,B=0x10}: 15 writes.
  - word0=0x003A4D42
  - word13 = {0x20,0x10,0x00,0x00}=0x20100000
  - word14=0x00000030 with WREN=0011, then DONE
- W=2,H=2, four pixels: fsize=70, word0=0x00464D42, pad 2 bytes/row, 18 writes, last WREN=0011.
- W=4,H=1 (pad=0), PIX_VALID toggled every other cycle: byte order is unaffected by stalls; no CS during stalls; word count is 17.
- WIDTH=0,HEIGHT=5: header only, fsize=54, 14 writes, last WREN=0011, PIX_READY never high.
- RST asserted during EMIT of a W=8,H=8 frame: all outputs 0 next cycle, no further CS. A new START completes a correct frame from ADDR 0.
- START pulsed mid-frame: ignored; the frame contents are identical to the undisturbed run.
